// File: rtl/uart_tx_stream.sv
// UART transmitter with a valid/ready input: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_tx_serial,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            dbg_state
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int IW    = $clog2(DATA_WIDTH) + 1;
  localparam int STOPS = (STOP_BITS == 2) ? 2 : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOPS - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("CLKS_PER_BIT out of range");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
    $error("DATA_WIDTH out of range");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           bit_idx;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                    parity;
`endif

  // Handshake: a word moves on any rising edge where i_valid && o_ready;
  // o_ready is a pure decode of IDLE, so upstream may hold i_valid high freely.
  assign o_ready   = (state == IDLE);
  assign o_busy    = !o_ready;
  assign dbg_state = state;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state       <= IDLE;
      o_tx_serial <= 1'b1;
      o_done      <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      stop_cnt    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx_serial <= 1'b1;
          cnt         <= '0;
          if (i_valid) begin
            shift       <= i_data;
`ifdef UART_TX_PARITY_EN
            parity      <= ^i_data;
`endif
            o_tx_serial <= 1'b0;
            state       <= START;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            bit_idx     <= '0;
            o_tx_serial <= shift[0];
            state       <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shift   <= {1'b0, shift[DATA_WIDTH-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              o_tx_serial <= parity ^ (PARITY_ODD != 0);
              state       <= PARITY;
`else
              o_tx_serial <= 1'b1;
              stop_cnt    <= 1'b0;
              state       <= STOP;
`endif
            end else begin
              o_tx_serial <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            o_tx_serial <= 1'b1;
            stop_cnt    <= 1'b0;
            state       <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          o_tx_serial <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              stop_cnt <= 1'b0;
              o_done   <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          o_tx_serial <= 1'b1;
          cnt         <= '0;
          stop_cnt    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: per-cycle expected {tx, ready, busy, done} queue for two
// instances (1 stop bit / even parity, 2 stop bits / odd parity).
module tb_uart_tx_stream;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL1 = CPB * (1 + 8 + P + 1);
  localparam int FL2 = CPB * (1 + 8 + P + 2);

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic       valid  = 1'b0;
  logic [7:0] data   = '0;
  logic       valid2 = 1'b0;
  logic [7:0] data2  = '0;
  logic       tx, ready, busy, done;
  logic       tx2, ready2, busy2, done2;
  logic [2:0] dbg, dbg2;

  logic [3:0] exp_q[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;
  bit         sel     = 1'b0;

  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
    .sysclk(sysclk), .rst(rst), .i_valid(valid), .i_data(data), .o_ready(ready),
    .o_tx_serial(tx), .o_busy(busy), .o_done(done), .dbg_state(dbg)
  );

  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
    .sysclk(sysclk), .rst(rst), .i_valid(valid2), .i_data(data2), .o_ready(ready2),
    .o_tx_serial(tx2), .o_busy(busy2), .o_done(done2), .dbg_state(dbg2)
  );

  // clock
  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_bit(input logic b);
    repeat (CPB) exp_q.push_back({b, 3'b010});
  endtask

  // Line model: start, LSB-first data, optional parity, stop bits, then the done/IDLE cycle.
  task automatic expect_frame(input logic [7:0] d, input int stops, input logic odd);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(d[i]);
`ifdef UART_TX_PARITY_EN
    push_bit((^d) ^ odd);
`else
    if (odd === 1'bx) push_bit(1'b0);
`endif
    for (int s = 0; s < stops; s++) push_bit(1'b1);
    exp_q.push_back(4'b1101);
  endtask

  task automatic run_cycles(input string tag, input int n, input bit scramble);
    logic [3:0] e;
    logic [3:0] obs;
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      obs = sel ? {tx2, ready2, busy2, done2} : {tx, ready, busy, done};
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: got %0h expected nothing queued", tag, obs);
      end else begin
        e = exp_q.pop_front();
        check_eq(tag, {28'd0, obs}, {28'd0, e});
      end
      if (scramble) begin
        data  = 8'($urandom_range(0, 255));
        data2 = 8'($urandom_range(0, 255));
      end
    end
  endtask

  // Single accept on the selected instance followed by the whole frame and its done cycle.
  task automatic send_frame(input string tag, input bit which, input logic [7:0] d);
    sel = which;
    expect_frame(d, which ? 2 : 1, which);
    if (which) begin valid2 = 1'b1; data2 = d; end
    else begin valid = 1'b1; data = d; end
    run_cycles(tag, 1, 1'b0);
    valid  = 1'b0;
    valid2 = 1'b0;
    run_cycles(tag, which ? FL2 : FL1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check_eq("rst_outs", {28'd0, tx, ready, busy, done}, 32'hC);
    check_eq("rst_outs2", {28'd0, tx2, ready2, busy2, done2}, 32'hC);
    check_eq("rst_state", {29'd0, dbg}, 32'd0);
    rst = 1'b0;

    // 1: single frame
    send_frame("t1_a5", 1'b0, 8'hA5);
    exp_q.push_back(4'b1100);
    run_cycles("t1_idle", 1, 1'b0);

    // 2: continuous valid, second accept on the done cycle
    sel = 1'b0;
    expect_frame(8'h00, 1, 1'b0);
    expect_frame(8'hFF, 1, 1'b0);
    valid = 1'b1;
    data  = 8'h00;
    run_cycles("t2_f0", 1, 1'b0);
    data = 8'hFF;
    run_cycles("t2_b2b", FL1 + 1, 1'b0);
    valid = 1'b0;
    run_cycles("t2_ff", FL1, 1'b0);

    // 3: parity sense on 0x07 (even on u_dut, odd on u_dut2)
    send_frame("t3_even", 1'b0, 8'h07);
    send_frame("t3_odd", 1'b1, 8'h07);

    // 4: two stop bits
    send_frame("t4_3c", 1'b1, 8'h3C);

    // 5: reset during data bit 3
    sel = 1'b0;
    expect_frame(8'h5A, 1, 1'b0);
    valid = 1'b1;
    data  = 8'h5A;
    run_cycles("t5_pre", 1, 1'b0);
    valid = 1'b0;
    run_cycles("t5_pre", 17, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(4'b1100);
    run_cycles("t5_rst", 1, 1'b0);
    check_eq("t5_state", {29'd0, dbg}, 32'd0);
    rst = 1'b0;
    exp_q.push_back(4'b1100);
    run_cycles("t5_nodone", 1, 1'b0);
    send_frame("t5_c3", 1'b0, 8'hC3);

    // 6: valid held with changing data while busy
    sel = 1'b0;
    expect_frame(8'h96, 1, 1'b0);
    valid = 1'b1;
    data  = 8'h96;
    run_cycles("t6_busy", FL1, 1'b1);
    valid = 1'b0;
    run_cycles("t6_done", 1, 1'b0);
    exp_q.push_back(4'b1100);
    run_cycles("t6_idle", 1, 1'b0);

    check_eq("q_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
